// File: rtl/sbtr_pkg.sv
// Shared types and constants for the saboteur (SBTR) scan-chain loader.
// FSM state encoding, fault-injection mode codes and chain/word sizing helper.
package sbtr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_ARM,
        ST_COMPLETE
    } sbtr_state_t;

    localparam logic [1:0] FI_MODE_PERM0  = 2'd0;
    localparam logic [1:0] FI_MODE_PERM1  = 2'd1;
    localparam logic [1:0] FI_MODE_TRANS0 = 2'd2;
    localparam logic [1:0] FI_MODE_TRANS1 = 2'd3;

    // Number of descriptor words needed to fill the chain, ceil(chain_len/word_w).
    function automatic int words_per_chain(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/sbtr_tfen_timer.sv
// Fault-window timer: counts cycles after DONE and produces the TFEn strobe.
// Static modes hold TFEn; transient modes pulse it once when the count reaches timeout.
module sbtr_tfen_timer
    import sbtr_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] timeout,
    input  logic             arm,
    output logic             TFEn,
    output logic             expired
);

    logic [1:0]       mode_q;
    logic [CNT_W-1:0] tmo_q;
    logic [CNT_W-1:0] cnt;
    logic             trans;
    logic             hit;

    assign trans = (mode_q >= FI_MODE_TRANS0);
    // Extra bit keeps timeout==0 from ever matching cnt+1.
    assign hit   = (({1'b0, cnt} + (CNT_W+1)'(1)) == {1'b0, tmo_q});
    // Static modes finish as soon as the chain is armed.
    assign expired = !trans || (arm && (cnt == tmo_q));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mode_q <= FI_MODE_PERM0;
            tmo_q  <= '0;
            cnt    <= '0;
            TFEn   <= 1'b0;
        end else if (clr) begin
            mode_q <= mode;
            tmo_q  <= timeout;
            cnt    <= '0;
            TFEn   <= 1'b0;
        end else if (arm) begin
            if (cnt < tmo_q) cnt <= cnt + CNT_W'(1);
            TFEn <= trans ? hit : 1'b1;
        end
    end

endmodule

// File: rtl/sbtr_chain_loader.sv
// SBTR scan-chain driver: accepts a fault descriptor, serializes it onto EN/SI,
// packs SO into readback words, then arms the fault window through the TFEn timer.
module sbtr_chain_loader
    import sbtr_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 32,
    parameter int CNT_W     = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_timeout,
    input  logic              word_valid,
    output logic              word_ready,
    input  logic [WORD_W-1:0] word_data,
    input  logic              SO,
    output logic              EN,
    output logic              SI,
    output logic              DONE,
    output logic              TFEn,
    output logic              rb_valid,
    output logic [WORD_W-1:0] rb_data,
    output logic              busy
);

    localparam int NWORDS    = words_per_chain(CHAIN_LEN, WORD_W);
    localparam int LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;
    localparam int BW        = $clog2(WORD_W + 1);
    localparam int NW        = $clog2(NWORDS + 1);

    sbtr_state_t       state, state_nxt;
    logic              cfg_acc, word_acc, expired;
    logic              sh_wend, sh_last, rb_wend, rb_last;
    logic [WORD_W-1:0] shreg, rb_sr, rb_next;
    logic [BW-1:0]     sh_bit, rb_bit;
    logic [NW-1:0]     sh_wrd, rb_wrd;

    assign cfg_ready  = (state == ST_IDLE) || (state == ST_COMPLETE);
    assign word_ready = (state == ST_LOAD);
    assign busy       = (state == ST_LOAD) || (state == ST_SHIFT) || (state == ST_ARM);
    assign cfg_acc    = cfg_valid && cfg_ready;
    assign word_acc   = word_valid && word_ready;

    // Shift side counts bits driven; readback side lags by one cycle and counts bits captured.
    assign sh_wend = (sh_bit == BW'(WORD_W - 1));
    assign sh_last = (sh_wrd == NW'(NWORDS - 1)) && (sh_bit == BW'(LAST_BITS - 1));
    assign rb_wend = (rb_bit == BW'(WORD_W - 1));
    assign rb_last = (rb_wrd == NW'(NWORDS - 1)) && (rb_bit == BW'(LAST_BITS - 1));
    assign rb_next = rb_sr | (WORD_W'(SO) << rb_bit);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_COMPLETE: if (cfg_acc) state_nxt = ST_LOAD;
            ST_LOAD:              if (word_acc) state_nxt = ST_SHIFT;
            ST_SHIFT: begin
                if (sh_last)      state_nxt = ST_ARM;
                else if (sh_wend) state_nxt = ST_LOAD;
            end
            ST_ARM:               if (expired) state_nxt = ST_COMPLETE;
            default:              state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            EN       <= 1'b0;
            SI       <= 1'b0;
            DONE     <= 1'b0;
            rb_valid <= 1'b0;
            rb_data  <= '0;
            rb_sr    <= '0;
            shreg    <= '0;
            sh_bit   <= '0;
            sh_wrd   <= '0;
            rb_bit   <= '0;
            rb_wrd   <= '0;
        end else begin
            rb_valid <= 1'b0;
            EN       <= (state == ST_SHIFT);
            SI       <= (state == ST_SHIFT) ? shreg[0] : 1'b0;
            if (cfg_acc) begin
                DONE   <= 1'b0;
                rb_sr  <= '0;
                sh_bit <= '0;
                sh_wrd <= '0;
                rb_bit <= '0;
                rb_wrd <= '0;
            end
            if (word_acc) shreg <= word_data;
            if (state == ST_SHIFT) begin
                shreg <= shreg >> 1;
                if (sh_wend) begin
                    sh_bit <= '0;
                    sh_wrd <= sh_wrd + NW'(1);
                end else begin
                    sh_bit <= sh_bit + BW'(1);
                end
            end
            if (state == ST_ARM) DONE <= 1'b1;
            // SO is valid for capture in every cycle the chain is actually shifting.
            if (EN) begin
                if (rb_wend || rb_last) begin
                    rb_valid <= 1'b1;
                    rb_data  <= rb_next;
                    rb_sr    <= '0;
                    rb_bit   <= '0;
                    rb_wrd   <= rb_wrd + NW'(1);
                end else begin
                    rb_sr  <= rb_next;
                    rb_bit <= rb_bit + BW'(1);
                end
            end
        end
    end

    sbtr_tfen_timer #(.CNT_W(CNT_W)) u_timer (
        .CLK     (CLK),
        .RST     (RST),
        .clr     (cfg_acc),
        .mode    (cfg_mode),
        .timeout (cfg_timeout),
        .arm     (DONE),
        .TFEn    (TFEn),
        .expired (expired)
    );

endmodule

// File: tb/tb_sbtr_chain_loader.sv
// Bench for sbtr_chain_loader: two instances (64-bit and 40-bit chains) with loopback chain models.
// SI/readback expectations are queued at stimulus time and popped by a negedge monitor.
module tb_sbtr_chain_loader;

    localparam int LEN0 = 64;
    localparam int LEN1 = 40;

    typedef struct {
        logic        s;
        logic [1:0]  mode;
        logic [31:0] tmo;
        logic [31:0] w0;
        logic [31:0] w1;
        int          gap;
        int          t_first;
        int          t_cnt;
        int          rdy_off;
    } vec_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic [1:0] cfg_valid = '0, word_valid = '0;
    logic [1:0] cfg_ready, word_ready, SO, EN, SI, DONE, TFEn, rb_valid, busy;
    logic [1:0][1:0]  cfg_mode = '0;
    logic [1:0][31:0] cfg_timeout = '0, word_data = '0;
    logic [1:0][31:0] rb_data;
    logic [1:0][63:0] chain = {64'h0000_00FF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};

    int checks = 0, failures = 0;
    int cyc = 0;
    int en_cnt [2];
    int last_en [2];
    logic        si_q0 [$], si_q1 [$];
    logic [31:0] rb_q0 [$], rb_q1 [$];
    vec_t tbl [8];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    sbtr_chain_loader #(.CHAIN_LEN(LEN0), .WORD_W(32), .CNT_W(32)) dut0 (
        .CLK(CLK), .RST(RST), .cfg_valid(cfg_valid[0]), .cfg_ready(cfg_ready[0]),
        .cfg_mode(cfg_mode[0]), .cfg_timeout(cfg_timeout[0]), .word_valid(word_valid[0]),
        .word_ready(word_ready[0]), .word_data(word_data[0]), .SO(SO[0]), .EN(EN[0]), .SI(SI[0]),
        .DONE(DONE[0]), .TFEn(TFEn[0]), .rb_valid(rb_valid[0]), .rb_data(rb_data[0]), .busy(busy[0]));

    sbtr_chain_loader #(.CHAIN_LEN(LEN1), .WORD_W(32), .CNT_W(32)) dut1 (
        .CLK(CLK), .RST(RST), .cfg_valid(cfg_valid[1]), .cfg_ready(cfg_ready[1]),
        .cfg_mode(cfg_mode[1]), .cfg_timeout(cfg_timeout[1]), .word_valid(word_valid[1]),
        .word_ready(word_ready[1]), .word_data(word_data[1]), .SO(SO[1]), .EN(EN[1]), .SI(SI[1]),
        .DONE(DONE[1]), .TFEn(TFEn[1]), .rb_valid(rb_valid[1]), .rb_data(rb_data[1]), .busy(busy[1]));

    // Chain models: bit 0 is the last cell (SO), SI enters at the top cell.
    assign SO[0] = chain[0][0];
    assign SO[1] = chain[1][0];
    always @(posedge CLK) begin
        if (EN[0]) chain[0] <= {SI[0], chain[0][63:1]};
        if (EN[1]) chain[1] <= {24'h0, SI[1], chain[1][39:1]};
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s unexpected event with empty scoreboard", nm);
    endtask

    task automatic push_si(input logic s, input logic b);
        if (s) si_q1.push_back(b);
        else   si_q0.push_back(b);
    endtask

    task automatic push_rb(input logic s, input logic [31:0] w);
        if (s) rb_q1.push_back(w);
        else   rb_q0.push_back(w);
    endtask

    task automatic mon(input logic s);
        logic e;
        logic [31:0] r;
        if (EN[s]) begin
            en_cnt[s]++;
            last_en[s] = cyc;
            if (s && si_q1.size() > 0) begin
                e = si_q1.pop_front();
                chk("si1", 64'(SI[s]), 64'(e));
            end else if (!s && si_q0.size() > 0) begin
                e = si_q0.pop_front();
                chk("si0", 64'(SI[s]), 64'(e));
            end else fail_now("si_extra");
        end
        if (rb_valid[s]) begin
            if (s && rb_q1.size() > 0) begin
                r = rb_q1.pop_front();
                chk("rb1", 64'(rb_data[s]), 64'(r));
            end else if (!s && rb_q0.size() > 0) begin
                r = rb_q0.pop_front();
                chk("rb0", 64'(rb_data[s]), 64'(r));
            end else fail_now("rb_extra");
        end
    endtask

    always @(negedge CLK) begin
        if (RST) begin
            mon(1'b0);
            mon(1'b1);
        end
    end

    task automatic chk_idle(input logic s);
        chk("rst_en", 64'(EN[s]), 64'd0);
        chk("rst_si", 64'(SI[s]), 64'd0);
        chk("rst_done", 64'(DONE[s]), 64'd0);
        chk("rst_tfen", 64'(TFEn[s]), 64'd0);
        chk("rst_busy", 64'(busy[s]), 64'd0);
        chk("rst_wrdy", 64'(word_ready[s]), 64'd0);
        chk("rst_rbv", 64'(rb_valid[s]), 64'd0);
        chk("rst_crdy", 64'(cfg_ready[s]), 64'd1);
    endtask

    task automatic run(input vec_t v);
        logic s, dn_ok;
        int len, t, first, cnt, rdy;
        logic [63:0] wv, snap, msk;
        s   = v.s;
        len = s ? LEN1 : LEN0;
        msk = s ? 64'h0000_00FF_FFFF_FFFF : '1;
        t = 0;
        while (!cfg_ready[s] && t < 100) begin @(negedge CLK); t++; end
        chk("cfg_wait", 64'(t < 100), 64'd1);
        // Readback returns whatever the chain held before this pass.
        snap = chain[s];
        wv = {v.w1, v.w0};
        for (int i = 0; i < len; i++) begin push_si(s, wv[0]); wv = wv >> 1; end
        push_rb(s, snap[31:0]);
        push_rb(s, snap[63:32]);
        en_cnt[s] = 0;
        cfg_valid[s] = 1'b1; cfg_mode[s] = v.mode; cfg_timeout[s] = v.tmo;
        word_valid[s] = 1'b1; word_data[s] = v.w0;
        @(negedge CLK);
        cfg_valid[s] = 1'b0;
        chk("acc_wrdy", 64'(word_ready[s]), 64'd1);
        chk("acc_busy", 64'(busy[s]), 64'd1);
        chk("acc_done_clr", 64'(DONE[s]), 64'd0);
        chk("acc_tfen_clr", 64'(TFEn[s]), 64'd0);
        @(negedge CLK);
        word_valid[s] = 1'b0;
        chk("en_lat1", 64'(EN[s]), 64'd0);
        @(negedge CLK);
        chk("en_lat2", 64'(EN[s]), 64'd1);
        t = 0;
        while (!word_ready[s] && t < 100) begin @(negedge CLK); t++; end
        chk("word_wait", 64'(t < 100), 64'd1);
        repeat (v.gap) begin
            @(negedge CLK);
            chk("gap_en", 64'(EN[s]), 64'd0);
        end
        word_valid[s] = 1'b1; word_data[s] = v.w1;
        @(negedge CLK);
        word_valid[s] = 1'b0;
        t = 0;
        while (!DONE[s] && t < 200) begin @(negedge CLK); t++; end
        chk("done_wait", 64'(t < 200), 64'd1);
        chk("done_lag", 64'(cyc - last_en[s]), 64'd1);
        chk("shifts", 64'(en_cnt[s]), 64'(len));
        chk("chain_img", chain[s], {v.w1, v.w0} & msk);
        first = -1; cnt = 0; rdy = -1; dn_ok = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge CLK);
            if (TFEn[s]) begin
                if (first < 0) first = k;
                cnt++;
            end
            if (cfg_ready[s] && rdy < 0) rdy = k;
            if (!DONE[s]) dn_ok = 1'b0;
        end
        chk("tfen_first", 64'(first), 64'(v.t_first));
        chk("tfen_cnt", 64'(cnt), 64'(v.t_cnt));
        chk("cfg_rdy_off", 64'(rdy), 64'(v.rdy_off));
        chk("done_hold", 64'(dn_ok), 64'd1);
        chk("si_left", 64'(s ? si_q1.size() : si_q0.size()), 64'd0);
        chk("rb_left", 64'(s ? rb_q1.size() : rb_q0.size()), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] wv;
        int t;
        //        s     mode  tmo     w0             w1             gap first cnt rdy
        tbl[0] = '{1'b0, 2'd0, 32'd0, 32'hDEADBEEF, 32'h12345678, 0,  1,   11, 0};
        tbl[1] = '{1'b0, 2'd1, 32'd9, 32'hDEADBEEF, 32'h12345678, 2,  1,   11, 0};
        tbl[2] = '{1'b0, 2'd2, 32'd5, 32'hA5A5F00F, 32'h0F0F3C3C, 1,  5,   1,  6};
        tbl[3] = '{1'b1, 2'd0, 32'd0, 32'hCAFEF00D, 32'hFFFFFFE7, 3,  1,   11, 0};
        tbl[4] = '{1'b1, 2'd3, 32'd0, 32'h13579BDF, 32'h0000005A, 0,  -1,  0,  1};
        tbl[5] = '{1'b0, 2'd3, 32'd1, 32'h00FF00FF, 32'h80000001, 0,  1,   1,  2};
        tbl[6] = '{1'b1, 2'd2, 32'd3, 32'h2468ACE0, 32'h000000C3, 1,  3,   1,  4};
        tbl[7] = '{1'b0, 2'd2, 32'd3, 32'h55AA33CC, 32'h0BADF00D, 0,  3,   1,  4};
        en_cnt[0] = 0; en_cnt[1] = 0; last_en[0] = 0; last_en[1] = 0;

        #12;
        chk_idle(1'b0);
        chk_idle(1'b1);
        chk("rst_rbd0", 64'(rb_data[0]), 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk_idle(1'b0);

        for (int i = 0; i < 7; i++) run(tbl[i]);

        // Abort a load mid-shift; outputs must drop without waiting for a clock edge.
        @(negedge CLK);
        wv = 64'(32'h0F1E2D3C);
        for (int i = 0; i < 32; i++) begin push_si(1'b0, wv[0]); wv = wv >> 1; end
        en_cnt[0] = 0;
        cfg_valid[0] = 1'b1; cfg_mode[0] = 2'd0; cfg_timeout[0] = 32'd0;
        word_valid[0] = 1'b1; word_data[0] = 32'h0F1E2D3C;
        @(negedge CLK);
        cfg_valid[0] = 1'b0;
        @(negedge CLK);
        word_valid[0] = 1'b0;
        t = 0;
        while (en_cnt[0] < 17 && t < 100) begin @(negedge CLK); #1; t++; end
        chk("abort_bit", 64'(en_cnt[0]), 64'd17);
        chk("abort_en_pre", 64'(EN[0]), 64'd1);
        #1 RST = 1'b0;
        #1;
        chk_idle(1'b0);
        si_q0.delete();
        rb_q0.delete();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        run(tbl[7]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
